// File: rtl/zx_cmd_mailbox.sv
// Z80-side end of the loader command channel: decodes I/O writes to one port into a
// 4-phase cpu_cmd/cpu_cmd_en/cpu_cmd_ack handshake and answers reads with a status byte.
module zx_cmd_mailbox #(
  parameter logic [7:0] PORT_ADDR      = 8'h5F,
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  input  logic        z80_iorq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_m1_n,
  output logic [7:0]  cpu_cmd,
  output logic        cpu_cmd_en,
  input  logic        cpu_cmd_ack,
  output logic        busy
);

  localparam int SW = 20;
  localparam logic [SW-1:0] SYNC_RST = {4'b1111, 16'h0000};
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  // Only the low address byte is decoded.
  logic unused_addr_hi;
  assign unused_addr_hi = ^z80_addr[15:8];

  // One chain for the whole bus so address/data stay aligned with the strobes.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SW-1:0] sync_s;
  logic          iorq_s, rd_s, wr_s, m1_s;
  logic [7:0]    addr_s, data_s;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_q[0] <= {z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n, z80_addr[7:0], z80_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign {iorq_s, rd_s, wr_s, m1_s, addr_s, data_s} = sync_s;

  logic wr_d, rd_d;
  logic wr_q, wr_prev_q, rd_q, rd_prev_q;
  logic [7:0] data_q;
  logic wr_rise, rd_rise, rd_fall;

  // M1 low with IORQ is an interrupt acknowledge, not a port access.
  assign wr_d = !iorq_s && !wr_s && m1_s && (addr_s == PORT_ADDR);
  assign rd_d = !iorq_s && !rd_s && m1_s && (addr_s == PORT_ADDR);

  assign wr_rise = wr_q && !wr_prev_q;
  assign rd_rise = rd_q && !rd_prev_q;
  assign rd_fall = !rd_q && rd_prev_q;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d, dout_q, dout_d;
  logic          to_q, to_d, ov_q, ov_d, oe_q, oe_d;
  logic          to_set, ov_set, cnt_hit;

  assign cnt_hit = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    to_d    = to_q;
    ov_d    = ov_q;
    to_set  = 1'b0;
    ov_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A stale ack (e.g. after a REQ timeout) blocks new commands.
        if (wr_rise) begin
          if (!cpu_cmd_ack) begin
            cmd_d   = data_q;
            state_d = S_REQ;
          end else begin
            ov_set = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (wr_rise) ov_set = 1'b1;
        if (cpu_cmd_ack) begin
          state_d = S_REL;
          cnt_d   = '0;
        end else if (cnt_hit) begin
          to_set  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REL: begin
        if (wr_rise) ov_set = 1'b1;
        if (!cpu_cmd_ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_hit) begin
          to_set  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A write on the same edge as a read takes precedence; the read is dropped.
    if (rd_rise && !wr_rise) begin
      dout_d = {state_q != S_IDLE, 5'b0, to_q, ov_q};
      oe_d   = 1'b1;
    end
    if (rd_fall && oe_q) begin
      oe_d = 1'b0;
      to_d = 1'b0;
      ov_d = 1'b0;
    end
    if (to_set) to_d = 1'b1;
    if (ov_set) ov_d = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_q      <= 1'b0;
      wr_prev_q <= 1'b0;
      rd_q      <= 1'b0;
      rd_prev_q <= 1'b0;
      data_q    <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      to_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      wr_prev_q <= wr_q;
      rd_q      <= rd_d;
      rd_prev_q <= rd_q;
      data_q    <= data_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      to_q      <= to_d;
      ov_q      <= ov_d;
    end
  end

  assign cpu_cmd      = cmd_q;
  assign cpu_cmd_en   = (state_q == S_REQ);
  assign busy         = (state_q != S_IDLE);
  assign z80_data_out = dout_q;
  assign z80_data_oe  = oe_q;

endmodule

// File: tb/tb_zx_cmd_mailbox.sv
// Bench for zx_cmd_mailbox: directed handshake/timeout/overrun/reset steps followed by
// randomized bus transactions checked against a transaction-level mailbox model.
module tb_zx_cmd_mailbox;

  localparam int SYNC = 2;
  localparam int TOUT = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [15:0] z80_addr;
  logic [7:0]  z80_data_in;
  logic [7:0]  z80_data_out;
  logic        z80_data_oe;
  logic        z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n;
  logic [7:0]  cpu_cmd;
  logic        cpu_cmd_en;
  logic        cpu_cmd_ack;
  logic        busy;

  zx_cmd_mailbox #(.PORT_ADDR(8'h5F), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .z80_addr(z80_addr), .z80_data_in(z80_data_in),
    .z80_data_out(z80_data_out), .z80_data_oe(z80_data_oe),
    .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n), .z80_m1_n(z80_m1_n),
    .cpu_cmd(cpu_cmd), .cpu_cmd_en(cpu_cmd_en), .cpu_cmd_ack(cpu_cmd_ack), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model of the mailbox as seen from the Z80 and the Nios.
  logic [7:0] m_cmd;
  logic       m_busy, m_to, m_ov;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic z80_out(input logic [15:0] a, input logic [7:0] d);
    z80_addr = a; z80_data_in = d; z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    repeat (4) tick();
    z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic z80_in(input logic [15:0] a, input logic m1n, output logic [7:0] v,
                        output logic oe);
    z80_addr = a; z80_m1_n = m1n; z80_iorq_n = 1'b0; z80_rd_n = 1'b0;
    repeat (5) tick();
    v = z80_data_out; oe = z80_data_oe;
    z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_m1_n = 1'b1;
    repeat (5) tick();
  endtask

  // Port read: status = {busy, 0, timeout, overrun}; a completed read clears the flags.
  task automatic read_status(input string tag);
    logic [7:0] v;
    logic       oe;
    z80_in({8'($urandom), 8'h5F}, 1'b1, v, oe);
    chk({tag, "_oe"}, {7'b0, oe}, 8'h01);
    chk(tag, v, {m_busy, 5'b0, m_to, m_ov});
    chk({tag, "_oe_rel"}, {7'b0, z80_data_oe}, 8'h00);
    m_to = 1'b0; m_ov = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [7:0] d, input int ack_dly,
                        input int rel_dly);
    z80_out({8'($urandom), 8'h5F}, d);
    m_cmd = d; m_busy = 1'b1;
    chk({tag, "_en"}, {7'b0, cpu_cmd_en}, 8'h01);
    chk({tag, "_cmd"}, cpu_cmd, m_cmd);
    repeat (ack_dly) tick();
    cpu_cmd_ack = 1'b1;
    tick();
    chk({tag, "_en_drop"}, {7'b0, cpu_cmd_en}, 8'h00);
    repeat (rel_dly) tick();
    cpu_cmd_ack = 1'b0;
    tick();
    m_busy = 1'b0;
    chk({tag, "_idle"}, {7'b0, busy}, 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    logic       oe;
    logic [7:0] d1, d2;
    reset_reset = 1'b1; cpu_cmd_ack = 1'b0;
    z80_addr = '0; z80_data_in = '0;
    z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_m1_n = 1'b1;
    m_cmd = 8'h00; m_busy = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    repeat (3) tick();
    reset_reset = 1'b0;
    chk("rst_en", {7'b0, cpu_cmd_en}, 8'h00);
    chk("rst_cmd", cpu_cmd, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_oe", {7'b0, z80_data_oe}, 8'h00);
    chk("rst_dout", z80_data_out, 8'h00);
    repeat (2) tick();

    // Basic OUT with exact enable latency and handshake timing.
    z80_addr = 16'h005F; z80_data_in = 8'hA3; z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    repeat (SYNC + 1) tick();
    chk("lat_early", {7'b0, cpu_cmd_en}, 8'h00);
    tick();
    chk("lat_en", {7'b0, cpu_cmd_en}, 8'h01);
    chk("lat_cmd", cpu_cmd, 8'hA3);
    z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
    repeat (5) tick();
    cpu_cmd_ack = 1'b1;
    tick();
    chk("ack_en", {7'b0, cpu_cmd_en}, 8'h00);
    chk("ack_busy", {7'b0, busy}, 8'h01);
    repeat (2) tick();
    cpu_cmd_ack = 1'b0;
    tick();
    chk("rel_busy", {7'b0, busy}, 8'h00);
    m_cmd = 8'hA3;
    read_status("in_basic");

    // Wrong port write and interrupt-acknowledge style read are ignored.
    z80_out(16'h005E, 8'h11);
    chk("wrong_port_en", {7'b0, cpu_cmd_en}, 8'h00);
    chk("wrong_port_cmd", cpu_cmd, m_cmd);
    z80_in(16'h005F, 1'b0, v, oe);
    chk("m1_oe", {7'b0, oe}, 8'h00);

    // Overrun while busy, status read during the handshake.
    z80_out(16'h005F, 8'h01);
    z80_out(16'h005F, 8'h02);
    m_cmd = 8'h01; m_busy = 1'b1; m_ov = 1'b1;
    chk("ovr_cmd", cpu_cmd, 8'h01);
    cpu_cmd_ack = 1'b1;
    tick();
    z80_in(16'h005F, 1'b1, v, oe);
    chk("ovr_in_busy", v, 8'h81);
    m_ov = 1'b0;
    cpu_cmd_ack = 1'b0;
    tick();
    m_busy = 1'b0;
    read_status("ovr_in_clr");

    // Overrun, status read after the handshake.
    z80_out(16'h005F, 8'h01);
    z80_out(16'h005F, 8'h02);
    cpu_cmd_ack = 1'b1; tick();
    cpu_cmd_ack = 1'b0; tick();
    z80_in(16'h005F, 1'b1, v, oe);
    chk("ovr_in_after", v, 8'h01);
    z80_in(16'h005F, 1'b1, v, oe);
    chk("ovr_in_second", v, 8'h00);

    // Timeout in REQ: enable drops exactly TOUT cycles after rising.
    z80_addr = 16'h005F; z80_data_in = 8'h77; z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    repeat (SYNC + 2) tick();
    chk("to_en", {7'b0, cpu_cmd_en}, 8'h01);
    z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
    repeat (TOUT - 1) tick();
    chk("to_en_hold", {7'b0, cpu_cmd_en}, 8'h01);
    tick();
    chk("to_en_drop", {7'b0, cpu_cmd_en}, 8'h00);
    chk("to_busy", {7'b0, busy}, 8'h00);
    m_cmd = 8'h77; m_to = 1'b1;
    repeat (3) tick();
    read_status("to_in");
    do_cmd("to_next", 8'h5C, 2, 2);

    // Ack stuck high in IDLE blocks new commands.
    cpu_cmd_ack = 1'b1;
    z80_out(16'h005F, 8'h33);
    m_ov = 1'b1;
    chk("stuck_en", {7'b0, cpu_cmd_en}, 8'h00);
    chk("stuck_cmd", cpu_cmd, m_cmd);
    read_status("stuck_in");
    cpu_cmd_ack = 1'b0;
    tick();
    do_cmd("stuck_retry", 8'h33, 1, 1);

    // Reset in the middle of REQ with the overrun flag set.
    z80_out(16'h005F, 8'h5A);
    z80_out(16'h005F, 8'h5B);
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    chk("mid_rst_en", {7'b0, cpu_cmd_en}, 8'h00);
    chk("mid_rst_cmd", cpu_cmd, 8'h00);
    chk("mid_rst_busy", {7'b0, busy}, 8'h00);
    m_cmd = 8'h00; m_busy = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    repeat (2) tick();
    read_status("mid_rst_in");

    // Randomized transactions against the model.
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: do_cmd("rnd_cmd", 8'($urandom), $urandom_range(1, 8), $urandom_range(1, 8));
        1: begin
          z80_out({8'($urandom), 8'h5F ^ 8'($urandom_range(1, 255))}, 8'($urandom));
          chk("rnd_wrong_en", {7'b0, cpu_cmd_en}, 8'h00);
          chk("rnd_wrong_cmd", cpu_cmd, m_cmd);
        end
        2: read_status("rnd_in");
        default: begin
          d1 = 8'($urandom); d2 = 8'($urandom);
          z80_out({8'($urandom), 8'h5F}, d1);
          z80_out({8'($urandom), 8'h5F}, d2);
          m_cmd = d1; m_ov = 1'b1;
          chk("rnd_ovr_cmd", cpu_cmd, m_cmd);
          cpu_cmd_ack = 1'b1; tick();
          cpu_cmd_ack = 1'b0; tick();
          chk("rnd_ovr_idle", {7'b0, busy}, 8'h00);
        end
      endcase
    end
    read_status("final_in");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
